set_host: RTL and testbench

SET_HOST -- requirements
Module: set_host

---
 rtl/set_host.sv | 107 ++++++++++
 tb/tb_set_host.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/set_host.sv
// Job host for the set-count engine: accepts a job, strobes the engine, waits for
// its result or a timeout, and holds the result until downstream consumes it.
module set_host #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    output logic             en,
    output logic [23:0]      central,
    output logic [11:0]      radius,
    output logic [1:0]       mode,
    input  logic             busy,
    input  logic             valid,
    input  logic [7:0]       candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [1:0]       res_mode,
    output logic             res_timeout,
    output logic [CNT_W-1:0] done_count,
    output logic             err_spurious
);
    // state | meaning
    // IDLE  | waiting for a job (only while no result is pending)
    // ISSUE | job latched, waiting for busy low to strobe en
    // WAIT  | engine running; valid or timer expiry ends the job
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic          accept;
    logic          issue_go;
    logic          res_ok;
    logic          res_to;

    assign job_ready = (state == IDLE) && !res_valid;
    assign accept    = job_valid && job_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_go = 1'b0;
        res_ok   = 1'b0;
        res_to   = 1'b0;
        case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: if (!busy) begin
                issue_go = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                // valid takes priority over a coincident timer expiry
                if (valid)                              res_ok = 1'b1;
                else if (timer == TW'(TIMEOUT - 1))     res_to = 1'b1;
                if (valid || res_to)                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en            <= 1'b0;
            timer         <= '0;
            central       <= '0;
            radius        <= '0;
            mode          <= '0;
            res_valid     <= 1'b0;
            res_candidate <= '0;
            res_mode      <= '0;
            res_timeout   <= 1'b0;
            done_count    <= '0;
            err_spurious  <= 1'b0;
        end else begin
            en <= issue_go;
            if (accept) begin
                central <= job_central;
                radius  <= job_radius;
                mode    <= job_mode;
            end
            if (issue_go)            timer <= '0;
            else if (state == WAIT)  timer <= timer + 1'b1;
            if (res_ok || res_to) begin
                res_valid     <= 1'b1;
                res_candidate <= res_ok ? candidate : 8'd0;
                res_mode      <= mode;
                res_timeout   <= res_to;
                done_count    <= done_count + 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
            if (valid && (state != WAIT)) err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_set_host.sv
// Directed bench for set_host: nominal job, busy stall, back-pressure, timeout,
// spurious valid, mid-job reset and valid/timeout collision.
module tb_set_host;
    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic [1:0]  res_mode;
    logic        res_timeout;
    logic [15:0] done_count;
    logic        err_spurious;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int en_base;
    int n;

    set_host #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
        .en(en), .central(central), .radius(radius), .mode(mode),
        .busy(busy), .valid(valid), .candidate(candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_mode(res_mode), .res_timeout(res_timeout), .done_count(done_count),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (en) en_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".en"}, 32'(en), 0);
        check({tag, ".central"}, 32'(central), 0);
        check({tag, ".radius"}, 32'(radius), 0);
        check({tag, ".mode"}, 32'(mode), 0);
        check({tag, ".res_valid"}, 32'(res_valid), 0);
        check({tag, ".res_cand"}, 32'(res_candidate), 0);
        check({tag, ".res_mode"}, 32'(res_mode), 0);
        check({tag, ".res_to"}, 32'(res_timeout), 0);
        check({tag, ".done"}, 32'(done_count), 0);
        check({tag, ".err"}, 32'(err_spurious), 0);
    endtask

    task automatic offer(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        job_valid   = 1'b1;
        job_central = c;
        job_radius  = r;
        job_mode    = m;
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; job_valid = 0; job_central = 0; job_radius = 0; job_mode = 0;
        busy = 0; valid = 0; candidate = 0; res_ready = 0;
        #1;
        check_zero("reset");
        check("reset.job_ready", 32'(job_ready), 1);
        tick(); tick();
        rst = 1'b0;

        // nominal job, engine answers 10 cycles after en
        en_base = en_cnt;
        offer(24'h443000, 12'h300, 2'd0);
        tick();
        job_valid = 0;
        check("nom.en_accept", 32'(en), 0);
        check("nom.central", 32'(central), 32'h443000);
        check("nom.radius", 32'(radius), 32'h300);
        tick();
        check("nom.en_t1", 32'(en), 1);
        repeat (9) tick();
        check("nom.en_single", 32'(en_cnt - en_base), 1);
        check("nom.no_res_yet", 32'(res_valid), 0);
        valid = 1; candidate = 8'd29;
        tick();
        valid = 0; candidate = 8'd0;
        check("nom.res_valid", 32'(res_valid), 1);
        check("nom.res_cand", 32'(res_candidate), 29);
        check("nom.res_mode", 32'(res_mode), 0);
        check("nom.res_to", 32'(res_timeout), 0);
        check("nom.done", 32'(done_count), 1);
        check("nom.job_ready", 32'(job_ready), 0);
        res_ready = 1;
        tick();
        res_ready = 0;
        check("nom.res_clear", 32'(res_valid), 0);
        check("nom.res_hold", 32'(res_candidate), 29);
        check("nom.job_ready2", 32'(job_ready), 1);

        // busy held for 5 cycles from accept
        en_base = en_cnt;
        busy = 1;
        offer(24'h123456, 12'habc, 2'd1);
        tick();
        job_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("busy.en_low", 32'(en), 0);
            check("busy.central", 32'(central), 32'h123456);
        end
        busy = 0;
        tick();
        check("busy.en_high", 32'(en), 1);
        busy = 1;   // ignored while waiting
        tick();
        check("busy.en_drop", 32'(en), 0);
        tick();
        valid = 1; candidate = 8'h55;
        tick();
        valid = 0; busy = 0;
        check("busy.en_single", 32'(en_cnt - en_base), 1);
        check("busy.res_valid", 32'(res_valid), 1);
        check("busy.res_cand", 32'(res_candidate), 32'h55);
        check("busy.res_mode", 32'(res_mode), 1);
        check("busy.done", 32'(done_count), 2);
        check("busy.radius", 32'(radius), 32'habc);
        check("busy.mode", 32'(mode), 1);

        // back-pressure: new job offered while result is pending
        offer(24'h111111, 12'h222, 2'd2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp.job_ready", 32'(job_ready), 0);
            check("bp.res_valid", 32'(res_valid), 1);
            check("bp.res_cand", 32'(res_candidate), 32'h55);
            check("bp.central", 32'(central), 32'h123456);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        check("bp.res_clear", 32'(res_valid), 0);
        check("bp.not_yet", 32'(central), 32'h123456);
        tick();
        job_valid = 0;
        check("bp.accepted", 32'(central), 32'h111111);
        check("bp.mode", 32'(mode), 2);

        // engine never answers: result 64 cycles after en
        tick();
        check("to.en", 32'(en), 1);
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        check("to.latency", 32'(n), 64);
        check("to.res_cand", 32'(res_candidate), 0);
        check("to.res_to", 32'(res_timeout), 1);
        check("to.res_mode", 32'(res_mode), 2);
        check("to.done", 32'(done_count), 3);
        res_ready = 1;
        tick();
        res_ready = 0;

        // spurious valid in IDLE
        valid = 1; candidate = 8'h77;
        tick();
        valid = 0;
        check("spur.err", 32'(err_spurious), 1);
        check("spur.res_valid", 32'(res_valid), 0);
        check("spur.done", 32'(done_count), 3);

        // reset while waiting on the engine
        offer(24'h0abcde, 12'h345, 2'd3);
        tick();
        job_valid = 0;
        tick();
        tick(); tick();
        rst = 1'b1;
        #1;
        check_zero("midrst");
        tick();
        rst = 1'b0;
        valid = 1;
        tick();
        valid = 0;
        check("midrst.spur", 32'(err_spurious), 1);
        check("midrst.no_res", 32'(res_valid), 0);

        // first job after reset; valid coincides with timer expiry
        offer(24'h0abcde, 12'h345, 2'd3);
        tick();
        job_valid = 0;
        tick();
        check("post.en", 32'(en), 1);
        repeat (63) tick();
        check("post.no_res_yet", 32'(res_valid), 0);
        valid = 1; candidate = 8'd7;
        tick();
        valid = 0;
        check("post.res_valid", 32'(res_valid), 1);
        check("post.res_to", 32'(res_timeout), 0);
        check("post.res_cand", 32'(res_candidate), 7);
        check("post.res_mode", 32'(res_mode), 3);
        check("post.done", 32'(done_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
